// File: rtl/fp_addsub_unpacker.sv
// Floating-point add/subtract front end.
// Stage 1 captures the packed operands and folds the opcode into B's sign.
// Stage 2 unpacks both words, orders them by magnitude, derives the effective
// operation and exponent difference, classifies specials and registers the
// result for the alignment shifter.
//
// Handshake: a word moves across a boundary on a rising edge where the
// producer's valid and the consumer's ready are both high. Each stage may
// load when it is empty or when the stage after it is draining. ready_o is
// derived only from pipeline occupancy and ready_i, never from valid_i.
// While valid_o is high and ready_i is low the output registers hold.
module fp_addsub_unpacker #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          op_i,
  input  logic [W-1:0]  A_i,
  input  logic [W-1:0]  B_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          sign_o,
  output logic          eff_sub_o,
  output logic          swap_o,
  output logic [EW-1:0] exp_large_o,
  output logic [EW-1:0] exp_diff_o,
  output logic [SW:0]   mant_large_o,
  output logic [SW:0]   mant_small_o,
  output logic          zero_o,
  output logic          inf_o,
  output logic          nan_o
);

  logic          s1_valid;
  logic          s2_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          adv1;
  logic          adv2;

  assign adv2    = !s2_valid || ready_i;
  assign adv1    = !s1_valid || adv2;
  assign ready_o = adv1;
  assign valid_o = s2_valid;

  // Stage 1: capture operands; B carries the opcode in its sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv1) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_a <= A_i;
        s1_b <= {B_i[W-1] ^ op_i, B_i[W-2:0]};
      end
    end
  end

  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [SW-1:0] a_frac, b_frac;
  logic [EW-1:0] a_eexp, b_eexp;
  logic [SW:0]   a_mant, b_mant;
  logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic          n_swap, n_sign, n_eff_sub, n_zero, n_inf, n_nan;
  logic [EW-1:0] n_exp_large, n_exp_small, n_exp_diff;
  logic [SW:0]   n_mant_large, n_mant_small;

  // Stage 2 combinational: unpack, order by magnitude and classify.
  always_comb begin
    a_sign = s1_a[W-1];
    b_sign = s1_b[W-1];
    a_exp  = s1_a[W-2:SW];
    b_exp  = s1_b[W-2:SW];
    a_frac = s1_a[SW-1:0];
    b_frac = s1_b[SW-1:0];

    // A zero exponent field is a subnormal: no hidden bit, exponent of 1.
    a_eexp = (a_exp == '0) ? EW'(1) : a_exp;
    b_eexp = (b_exp == '0) ? EW'(1) : b_exp;
    a_mant = {(a_exp != '0), a_frac};
    b_mant = {(b_exp != '0), b_frac};

    a_nan  = (&a_exp) && (a_frac != '0);
    b_nan  = (&b_exp) && (b_frac != '0);
    a_inf  = (&a_exp) && (a_frac == '0);
    b_inf  = (&b_exp) && (b_frac == '0);
    a_zero = (a_exp == '0) && (a_frac == '0);
    b_zero = (b_exp == '0) && (b_frac == '0);

    // Magnitude order on {exp,frac}; ties keep A as the larger operand.
    n_swap    = (s1_b[W-2:0] > s1_a[W-2:0]);
    n_sign    = n_swap ? b_sign : a_sign;
    n_eff_sub = a_sign ^ b_sign;

    n_exp_large  = n_swap ? b_eexp : a_eexp;
    n_exp_small  = n_swap ? a_eexp : b_eexp;
    n_mant_large = n_swap ? b_mant : a_mant;
    n_mant_small = n_swap ? a_mant : b_mant;
    n_exp_diff   = n_exp_large - n_exp_small;

    n_nan  = a_nan || b_nan || (a_inf && b_inf && n_eff_sub);
    n_inf  = !n_nan && (a_inf || b_inf);
    n_zero = a_zero && b_zero;
  end

  // Stage 2 registers: load only when the output slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      sign_o       <= 1'b0;
      eff_sub_o    <= 1'b0;
      swap_o       <= 1'b0;
      exp_large_o  <= '0;
      exp_diff_o   <= '0;
      mant_large_o <= '0;
      mant_small_o <= '0;
      zero_o       <= 1'b0;
      inf_o        <= 1'b0;
      nan_o        <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sign_o       <= n_sign;
        eff_sub_o    <= n_eff_sub;
        swap_o       <= n_swap;
        exp_large_o  <= n_exp_large;
        exp_diff_o   <= n_exp_diff;
        mant_large_o <= n_mant_large;
        mant_small_o <= n_mant_small;
        zero_o       <= n_zero;
        inf_o        <= n_inf;
        nan_o        <= n_nan;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_unpacker.sv
// Bench for fp_addsub_unpacker: reference model of the unpack rules, an
// expected-result queue filled on every input transfer and drained on every
// output transfer, plus directed scenarios for stall, throughput and reset.
module tb_fp_addsub_unpacker;

  typedef struct packed {
    logic        sign;
    logic        eff_sub;
    logic        swap;
    logic [7:0]  exp_large;
    logic [7:0]  exp_diff;
    logic [23:0] mant_large;
    logic [23:0] mant_small;
    logic        zero;
    logic        inf;
    logic        nan;
  } res_t;

  localparam int RW = $bits(res_t);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        op_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        sign_o, eff_sub_o, swap_o, zero_o, inf_o, nan_o;
  logic [7:0]  exp_large_o, exp_diff_o;
  logic [23:0] mant_large_o, mant_small_o;

  int tests = 0;
  int fails = 0;
  int n_out = 0;
  logic [RW-1:0] exp_q[$];

  fp_addsub_unpacker #(.W(32), .EW(8), .SW(23)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .A_i(a_i), .B_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .sign_o(sign_o), .eff_sub_o(eff_sub_o), .swap_o(swap_o),
    .exp_large_o(exp_large_o), .exp_diff_o(exp_diff_o),
    .mant_large_o(mant_large_o), .mant_small_o(mant_small_o),
    .zero_o(zero_o), .inf_o(inf_o), .nan_o(nan_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t r;
    int unsigned mag_a, mag_b, ea, eb, fa, fb, eea, eeb, ma, mb;
    bit sa, sb, nan_a, nan_b, inf_a, inf_b;
    sa = a[31];
    sb = b[31] ^ op;
    mag_a = a & 32'h7FFF_FFFF;
    mag_b = b & 32'h7FFF_FFFF;
    ea = mag_a / (1 << 23);
    eb = mag_b / (1 << 23);
    fa = mag_a % (1 << 23);
    fb = mag_b % (1 << 23);
    eea = (ea == 0) ? 1 : ea;
    eeb = (eb == 0) ? 1 : eb;
    ma = (ea == 0) ? fa : fa + (1 << 23);
    mb = (eb == 0) ? fb : fb + (1 << 23);
    nan_a = (ea == 255) && (fa != 0);
    nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0);
    inf_b = (eb == 255) && (fb == 0);
    r.eff_sub = sa ^ sb;
    r.swap    = mag_b > mag_a;
    r.sign    = r.swap ? sb : sa;
    r.exp_large  = 8'(r.swap ? eeb : eea);
    r.exp_diff   = 8'(r.swap ? eeb - eea : eea - eeb);
    r.mant_large = 24'(r.swap ? mb : ma);
    r.mant_small = 24'(r.swap ? ma : mb);
    r.nan  = nan_a || nan_b || (inf_a && inf_b && r.eff_sub);
    r.inf  = !r.nan && (inf_a || inf_b);
    r.zero = (mag_a == 0) && (mag_b == 0);
    return r;
  endfunction

  // Exponent and mantissa fields are unspecified for NaN/Inf results.
  function automatic bit res_match(input res_t g, input res_t e);
    if (e.nan || e.inf)
      return {g.sign, g.eff_sub, g.swap, g.zero, g.inf, g.nan} ==
             {e.sign, e.eff_sub, e.swap, e.zero, e.inf, e.nan};
    return g == e;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.sign = sign_o; r.eff_sub = eff_sub_o; r.swap = swap_o;
    r.exp_large = exp_large_o; r.exp_diff = exp_diff_o;
    r.mant_large = mant_large_o; r.mant_small = mant_small_o;
    r.zero = zero_o; r.inf = inf_o; r.nan = nan_o;
    return r;
  endfunction

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Pin the model against hand-computed results.
  task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b, input logic op,
                     input res_t want);
    res_t g;
    g = model(a, b, op);
    tests++;
    if (!res_match(g, want)) begin
      fails++;
      $display("FAIL pin_%s: model %h expected %h", name, g, want);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  res_t held;
  bit   hold = 0;
  always @(negedge clk) begin
    res_t cur, e;
    cur = dut_res();
    if (rst) begin
      hold = 0;
    end else begin
      if (hold && valid_o) begin
        tests++;
        if (cur !== held) begin
          fails++;
          $display("FAIL stall_stable: got %h expected %h", cur, held);
        end
      end
      if (valid_i && ready_o) exp_q.push_back(model(a_i, b_i, op_i));
      if (valid_o && ready_i) begin
        n_out++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (!res_match(cur, e)) begin
            fails++;
            $display("FAIL result: got %h expected %h", cur, e);
          end
        end
      end
      hold = valid_o && !ready_i;
      held = cur;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; the sender holds a word
  // until the edge on which ready_o is high.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
    bit done;
    done = 0;
    a_i = a; b_i = b; op_i = op; valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = ready_o;
      @(posedge clk); #1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: got ready_o=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    valid_i = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (exp_q.size() == 0) && !valid_o;
    end
    check("drain", {31'd0, ok}, {31'd0, 1'b1});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    res_t p;
    int   start_out;

    // Model pins (hand-computed).
    p = '{sign:0, eff_sub:0, swap:1, exp_large:8'h80, exp_diff:8'd1,
          mant_large:24'h800000, mant_small:24'h800000, zero:0, inf:0, nan:0};
    pin("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, p);
    p = '{sign:0, eff_sub:1, swap:0, exp_large:8'h80, exp_diff:8'd1,
          mant_large:24'hC00000, mant_small:24'h800000, zero:0, inf:0, nan:0};
    pin("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, p);
    p = '{sign:0, eff_sub:0, swap:0, exp_large:8'd1, exp_diff:8'd0,
          mant_large:24'h000001, mant_small:24'h000000, zero:0, inf:0, nan:0};
    pin("subnormal", 32'h00000001, 32'h00000000, 1'b0, p);
    p = '{sign:1, eff_sub:0, swap:0, exp_large:8'd1, exp_diff:8'd0,
          mant_large:24'h0, mant_small:24'h0, zero:1, inf:0, nan:0};
    pin("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, p);
    p = '{sign:0, eff_sub:1, swap:0, exp_large:8'h0, exp_diff:8'h0,
          mant_large:24'h0, mant_small:24'h0, zero:0, inf:0, nan:1};
    pin("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, p);
    p = '{sign:0, eff_sub:0, swap:0, exp_large:8'h0, exp_diff:8'h0,
          mant_large:24'h0, mant_small:24'h0, zero:0, inf:1, nan:0};
    pin("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, p);
    p = '{sign:1, eff_sub:1, swap:1, exp_large:8'h80, exp_diff:8'd1,
          mant_large:24'h800000, mant_small:24'h800000, zero:0, inf:0, nan:0};
    pin("neg_b_larger", 32'h3F800000, 32'hC0000000, 1'b0, p);

    // Reset.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", dut_res(), '0);
    check("reset_handshake", {30'd0, valid_o, ready_o}, {30'd0, 1'b0, 1'b1});

    // Isolated first transfer: latency check.
    send(32'h3F800000, 32'h40000000, 1'b0);
    valid_i = 1'b0;
    check("latency_1cyc", {31'd0, valid_o}, {31'd0, 1'b0});
    @(posedge clk); #1;
    check("latency_2cyc", {31'd0, valid_o}, {31'd0, 1'b1});
    check("first_result", dut_res(),
          {1'b0, 1'b0, 1'b1, 8'h80, 8'd1, 24'h800000, 24'h800000, 3'b000});
    idle(2);

    // Directed vectors, streamed back to back.
    send(32'h40400000, 32'h3F800000, 1'b1);
    send(32'h00000001, 32'h00000000, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0);
    send(32'h7F800000, 32'h7F800000, 1'b1);
    send(32'h7FC00000, 32'h3F800000, 1'b0);
    send(32'h7F800000, 32'h3F800000, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b1);
    send(32'h3F800000, 32'hC0000000, 1'b0);
    send(32'h00400000, 32'h00800000, 1'b1);
    send(32'h4B000000, 32'h3F000000, 1'b0);
    drain();

    // Throughput: 6 pairs in 6 cycles with ready_i held high.
    start_out = n_out;
    for (int i = 0; i < 6; i++) send(32'h40000000 + 32'(i << 20), 32'h3F800000 + 32'(i), i[0]);
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("throughput", 32'(n_out - start_out), 32'd5);
    drain();

    // Stall: 4 pairs with ready_i low for 3 cycles after the pipe fills.
    start_out = n_out;
    ready_i = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h40000000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1);
        send(32'hC0A00000, 32'h40A00000, 1'b0);
        send(32'h00000003, 32'h80000002, 1'b1);
        valid_i = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("stall_ready_low", {31'd0, ready_o}, {31'd0, 1'b0});
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("stall_count", 32'(n_out - start_out), 32'd4);

    // Reset with both stages full: nothing in flight may come out.
    ready_i = 1'b0;
    send(32'h41200000, 32'h40000000, 1'b0);
    send(32'h41300000, 32'h40000000, 1'b1);
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_handshake", {30'd0, valid_o, ready_o}, {30'd0, 1'b0, 1'b1});
    ready_i = 1'b1;
    start_out = n_out;
    idle(6);
    check("midreset_no_stale", 32'(n_out - start_out), 32'd0);

    // Operation resumes after reset.
    send(32'h40400000, 32'h3F800000, 1'b1);
    send(32'h7FC00000, 32'h00000000, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
